// File: rtl/wbc_vic_prio.sv
// ---------------------------------------------------------------------------
// wbc_vic_prio -- multi-level vectored interrupt controller
//
// Arbitrates N level-sensitive request lines. Each line has its own bus
// request level (BR4..BR7) and its own 16-bit vector. Requests at or below
// the processor priority are masked. The highest eligible level wins. Ties
// within a level go to the lowest index by default. With VIC_ROUND_ROBIN_EN
// defined, each level instead keeps a rotating pointer.
//
// Vector-fetch handshake (stb/ack):
//   wb_irq_o/wb_lev_o announce a pending request. The CPU raises wb_stb_i to
//   fetch the vector. The edge that samples wb_stb_i=1 while a request is
//   pending registers wb_dat_o, wb_ack_o and iack[winner] for exactly one
//   cycle. The CPU then drops wb_stb_i. The next request is not announced
//   until the controller has been back in IDLE for one cycle, so one strobe
//   can never see two acks.
//
// Ports:
//   wb_clk_i  in   1     system clock
//   wb_rst_i  in   1     asynchronous active-high reset
//   wb_irq_o  out  1     interrupt request to CPU
//   wb_lev_o  out  3     level of pending request (4..7), 0 when none
//   wb_dat_o  out  16    vector returned to CPU
//   wb_stb_i  in   1     CPU vector-fetch strobe
//   wb_ack_o  out  1     vector-valid acknowledge
//   cpu_pri   in   3     current processor priority
//   ivec      in   N*16  per-line vectors, line i = ivec[16i+15:16i]
//   ilev      in   N*2   per-line level, line i = 4 + ilev[2i+1:2i]
//   ireq      in   N     request lines, level-sensitive
//   iack      out  N     one-cycle grant pulse to the granted line
//
// Optional feature macro: VIC_ROUND_ROBIN_EN (per-level rotating tie-break)
// ---------------------------------------------------------------------------
module wbc_vic_prio #(
    parameter int N = 1
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    output logic            wb_irq_o,
    output logic [2:0]      wb_lev_o,
    output logic [15:0]     wb_dat_o,
    input  logic            wb_stb_i,
    output logic            wb_ack_o,
    input  logic [2:0]      cpu_pri,
    input  logic [N*16-1:0] ivec,
    input  logic [N*2-1:0]  ilev,
    input  logic [N-1:0]    ireq,
    output logic [N-1:0]    iack
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t          state_q;
    logic            irq_q;
    logic [2:0]      lev_q;
    logic [15:0]     dat_q;
    logic            ack_q;
    logic [N-1:0]    iack_q;
    logic [W-1:0]    nvec_q;

    // Per-level search start index (0 for fixed priority, pointer for RR)
    logic [W-1:0]    start_idx [4];

    logic [N-1:0]    elig;
    logic [3:0]      lvl_found;
    logic [W-1:0]    lvl_idx [4];
    logic            any_elig;
    logic [W-1:0]    win_idx;
    logic [1:0]      win_lev;
    logic [15:0]     grant_vec;
    logic [N-1:0]    grant_oh;

    // Line is eligible when its level (4 + ilev) is strictly above cpu_pri
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = ireq[i] && ({1'b1, ilev[2*i +: 2]} > cpu_pri);
        end
    end

    // For each level, find the first eligible line at or after that level's
    // start index, wrapping around.
    always_comb begin
        int j;
        j = 0;
        for (int l = 0; l < 4; l++) begin
            lvl_found[l] = 1'b0;
            lvl_idx[l]   = '0;
            for (int k = 0; k < N; k++) begin
                j = int'(start_idx[l]) + k;
                if (j >= N) begin
                    j = j - N;
                end
                if (!lvl_found[l] && elig[j] && (ilev[2*j +: 2] == 2'(l))) begin
                    lvl_found[l] = 1'b1;
                    lvl_idx[l]   = W'(j);
                end
            end
        end
    end

    // Highest populated level wins; ascending scan lets later levels override
    always_comb begin
        any_elig = 1'b0;
        win_idx  = '0;
        win_lev  = 2'd0;
        for (int l = 0; l < 4; l++) begin
            if (lvl_found[l]) begin
                any_elig = 1'b1;
                win_idx  = lvl_idx[l];
                win_lev  = 2'(l);
            end
        end
    end

    // Vector and one-hot grant for the frozen winner
    always_comb begin
        grant_vec = '0;
        grant_oh  = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(nvec_q) == i) begin
                grant_vec   = ivec[16*i +: 16];
                grant_oh[i] = 1'b1;
            end
        end
    end

`ifdef VIC_ROUND_ROBIN_EN
    logic [W-1:0] ptr_q [4];
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = (int'(nvec_q) >= N - 1) ? '0 : nvec_q + W'(1);
        for (int l = 0; l < 4; l++) begin
            start_idx[l] = ptr_q[l];
        end
    end

    // lev_q holds 4+level while in REQ, so its low bits select the pointer
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int l = 0; l < 4; l++) begin
                ptr_q[l] <= '0;
            end
        end else if (state_q == S_REQ && wb_stb_i) begin
            ptr_q[lev_q[1:0]] <= ptr_d;
        end
    end
`else
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            start_idx[l] = '0;
        end
    end
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
            lev_q   <= 3'd0;
            dat_q   <= 16'd0;
            ack_q   <= 1'b0;
            iack_q  <= '0;
            nvec_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A strobe arriving with nothing announced is ignored
                    if (any_elig && !wb_stb_i) begin
                        nvec_q  <= win_idx;
                        irq_q   <= 1'b1;
                        lev_q   <= {1'b1, win_lev};
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (wb_stb_i) begin
                        // Winner is frozen from the last arbitration; late
                        // request changes no longer matter.
                        dat_q   <= grant_vec;
                        ack_q   <= 1'b1;
                        iack_q  <= grant_oh;
                        irq_q   <= 1'b0;
                        lev_q   <= 3'd0;
                        state_q <= S_ACK;
                    end else if (any_elig) begin
                        nvec_q  <= win_idx;
                        lev_q   <= {1'b1, win_lev};
                    end else begin
                        irq_q   <= 1'b0;
                        lev_q   <= 3'd0;
                        state_q <= S_IDLE;
                    end
                end
                S_ACK: begin
                    ack_q   <= 1'b0;
                    iack_q  <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (!wb_stb_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wb_irq_o = irq_q;
    assign wb_lev_o = lev_q;
    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign iack     = iack_q;

endmodule

// File: doc/wbc_vic_prio.md
Name: wbc_vic_prio

Overview:
- Multi-level vectored interrupt controller for the Wishbone CPU core; successor to the single-level fixed-priority vector controller.
- Supports N request lines, each with its own bus-request level BR4..BR7 and its own 16-bit vector.
- Masks requests against the processor priority (PS[7:5]).
- Presents the winning vector to the CPU over the existing stb/ack vector-fetch handshake and pulses iack to the granted device.

Parameters:
- N, 1, number of interrupt lines (1..32)
- W, derived, bits to index a line: max(1, ceil(log2(N)))

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  asynchronous active-high reset
- wb_irq_o  out  1  interrupt request to CPU
- wb_lev_o  out  3  level of pending request (4..7); 0 when none
- wb_dat_o  out  16  vector returned to CPU
- wb_stb_i  in  1  CPU vector-fetch strobe
- wb_ack_o  out  1  vector-valid acknowledge
- cpu_pri  in  3  current processor priority
- ivec  in  N*16  vectors; line i = ivec[16i+15:16i]
- ilev  in  N*2  per-line level; line i = 4 + ilev[2i+1:2i]
- ireq  in  N  request lines, level-sensitive
- iack  out  N  one-cycle grant pulse to the granted line

Behaviour:
- Reset (async, wb_rst_i=1):
  - wb_irq_o=0, wb_ack_o=0, wb_lev_o=0, wb_dat_o=0, iack=0.
  - FSM=IDLE, winner register cleared.
- Eligibility: line i is eligible when ireq[i]=1 and (4+ilev[i]) > cpu_pri.
- Arbitration (combinational):
  - The highest level among eligible lines wins.
  - Ties go to the lowest index (see Optional Feature).
- FSM states: IDLE, REQ, ACK, WAIT.
- IDLE:
  - If an eligible line exists and wb_stb_i=0: latch nvec/nlev, wb_irq_o<=1, wb_lev_o<=nlev, go to REQ.
  - wb_irq_o rises exactly one clock after the eligible request is sampled.
  - wb_stb_i seen in IDLE is ignored: no ack, no iack.
- REQ, wb_stb_i=0:
  - Re-arbitrate every cycle and update nvec/nlev. A higher-level arrival preempts.
  - If no eligible line remains (request withdrawn, or cpu_pri raised): wb_irq_o<=0, wb_lev_o<=0, go to IDLE.
- REQ, wb_stb_i=1:
  - Freeze nvec.
  - Next edge: wb_dat_o<=ivec[nvec], wb_ack_o<=1, iack[nvec]<=1, wb_irq_o<=0, wb_lev_o<=0, go to ACK.
  - ireq/cpu_pri changes after strobe sampling do not cancel the grant.
- ACK:
  - wb_ack_o and iack drop after exactly one cycle.
  - wb_dat_o holds the vector.
  - Go to WAIT.
- WAIT:
  - Stay while wb_stb_i=1.
  - On wb_stb_i=0, go to IDLE.
  - A new request can raise wb_irq_o no earlier than one cycle after IDLE is entered, so there are no back-to-back acks within one strobe.
- Invariants:
  - At most one iack bit is set at a time; iack is never set without wb_ack_o in the same cycle.
  - A line still holding ireq after its iack is re-arbitrated normally once WAIT exits.
- Reset mid-handshake aborts immediately to the reset values; any in-progress ack is lost.
- N=1: W=1, and the single line always wins when eligible.

Optional Feature:
- Macro: VIC_ROUND_ROBIN_EN.
- When defined:
  - Each of the 4 levels keeps a W-bit rotating pointer, reset to 0.
  - Tie-break within a level picks the first eligible index at or after that level's pointer, with wrap-around.
  - On each grant, the granted level's pointer <= nvec+1 (mod N).
- When undefined:
  - Fixed lowest-index-wins tie-break.
  - No pointer registers are synthesised.

Test Plan:
- N=4, cpu_pri=0, ireq=0010, ilev[1]=2 (BR6), ivec[1]=0o060 -> wb_irq_o=1 one clock later, wb_lev_o=6. Strobe gives wb_dat_o=0o060, wb_ack_o and iack[1] high for exactly one cycle.
- Lines 0 (BR4, 0o100) and 3 (BR7, 0o300) request together, cpu_pri=0 -> vector 0o300 granted, iack=1000. After stb drops and line 0 still requests, the next grant is 0o100.
- Line 2 at BR5, cpu_pri=5 -> wb_irq_o stays 0. Lower cpu_pri to 4 -> wb_irq_o=1 next cycle, wb_lev_o=5.
- While in REQ with BR4 pending and no strobe, assert a BR7 line -> wb_lev_o changes 4->7 and the strobe returns the BR7 vector. Separately, withdraw ireq before the strobe -> wb_irq_o falls and no ack follows.
- Assert wb_rst_i asynchronously during ACK -> all outputs are 0 immediately. After release with ireq still high, the request is re-raised one clock later.
- With VIC_ROUND_ROBIN_EN, lines 0,1,2 all BR4 and held -> successive grants are 0,1,2,0. Without the macro -> grants are 0,0,0.
